control_unit: RTL and testbench



---
 rtl/control_unit.sv | 161 ++++++++++++++++
 tb/tb_control_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: ID-stage main decoder of the MIPS pipeline.
// Maps opcode/funct of the instruction in decode to a registered 20-bit
// control word. The word is held while i_enable is low and cleared by
// the synchronous reset.
module control_unit #(
   parameter int NB_SGN = 20,
   parameter int NB_OP  = 6
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic [NB_OP-1:0]  i_inst_opcode,
   input  logic [NB_OP-1:0]  i_inst_function,
   output logic [NB_SGN-1:0] o_signals
);

   // ALU operation codes carried in bits 13:10 of the control word
   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_ADDU  = 4'b0001;
   localparam logic [3:0] ALU_RTYPE = 4'b0010;
   localparam logic [3:0] ALU_AND   = 4'b0100;
   localparam logic [3:0] ALU_OR    = 4'b0101;
   localparam logic [3:0] ALU_BRCMP = 4'b0111;
   localparam logic [3:0] ALU_XOR   = 4'b1000;
   localparam logic [3:0] ALU_LUI   = 4'b1001;
   localparam logic [3:0] ALU_SLT   = 4'b1100;
   localparam logic [3:0] ALU_SLTU  = 4'b1101;

   // Individual control fields, assembled into the word below
   logic       jump;
   logic       jump_reg;
   logic       branch;
   logic       branch_eq;
   logic       alu_src_imm;
   logic       i_format;
   logic [3:0] alu_op;
   logic       dst_ra;
   logic       mem_read;
   logic       mem_write;
   logic       mem_unsigned;
   logic [1:0] mem_width;
   logic       mem_to_reg;
   logic       reg_write;
   logic       link;
   logic       halt;

   logic [NB_SGN-1:0] signals_next;
   logic [NB_SGN-1:0] signals_reg;

   // Combinational decode of opcode (and funct for R-type) into fields
   always_comb begin
      jump         = 1'b0;
      jump_reg     = 1'b0;
      branch       = 1'b0;
      branch_eq    = 1'b0;
      alu_src_imm  = 1'b0;
      i_format     = 1'b0;
      alu_op       = ALU_ADD;
      dst_ra       = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      mem_unsigned = 1'b0;
      mem_width    = 2'b00;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      link         = 1'b0;
      halt         = 1'b0;

      case (i_inst_opcode)
         6'b000000: begin
            // funct is only looked at here, so X on it elsewhere is harmless
            case (i_inst_function)
               6'b001000: jump_reg = 1'b1;                 // JR
               6'b001001: begin                            // JALR
                  jump_reg  = 1'b1;
                  reg_write = 1'b1;
                  link      = 1'b1;
               end
               6'b111111: halt = 1'b1;                     // HALT
               6'b000000, 6'b000010, 6'b000011,
               6'b000100, 6'b000110, 6'b000111,
               6'b100001, 6'b100011, 6'b100100,
               6'b100101, 6'b100110, 6'b100111,
               6'b101010, 6'b101011: begin                 // ALU ops
                  alu_op    = ALU_RTYPE;
                  reg_write = 1'b1;
               end
               default: ;                                  // bubble
            endcase
         end
         6'b000100: begin                                  // BEQ
            branch    = 1'b1;
            branch_eq = 1'b1;
            alu_op    = ALU_BRCMP;
         end
         6'b000101: begin                                  // BNE
            branch = 1'b1;
            alu_op = ALU_BRCMP;
         end
         6'b000010: jump = 1'b1;                           // J
         6'b000011: begin                                  // JAL
            jump      = 1'b1;
            dst_ra    = 1'b1;
            reg_write = 1'b1;
            link      = 1'b1;
         end
         6'b100000, 6'b100001, 6'b100011,
         6'b100100, 6'b100101, 6'b100111: begin            // loads
            alu_src_imm  = 1'b1;
            i_format     = 1'b1;
            mem_read     = 1'b1;
            mem_to_reg   = 1'b1;
            reg_write    = 1'b1;
            // opcode bit 2 selects zero-extension, bits 1:0 match the width code
            mem_unsigned = i_inst_opcode[2];
            mem_width    = i_inst_opcode[1:0];
         end
         6'b101000, 6'b101001, 6'b101011: begin            // stores
            alu_src_imm = 1'b1;
            i_format    = 1'b1;
            mem_write   = 1'b1;
            mem_width   = i_inst_opcode[1:0];
         end
         6'b001000, 6'b001001, 6'b001010, 6'b001011,
         6'b001100, 6'b001101, 6'b001110, 6'b001111: begin // immediates
            alu_src_imm = 1'b1;
            i_format    = 1'b1;
            reg_write   = 1'b1;
            case (i_inst_opcode[2:0])
               3'b000:  alu_op = ALU_ADD;
               3'b001:  alu_op = ALU_ADDU;
               3'b010:  alu_op = ALU_SLT;
               3'b011:  alu_op = ALU_SLTU;
               3'b100:  alu_op = ALU_AND;
               3'b101:  alu_op = ALU_OR;
               3'b110:  alu_op = ALU_XOR;
               default: alu_op = ALU_LUI;
            endcase
         end
         default: ;                                        // unknown opcode: bubble
      endcase
   end

   // Pack fields into the control word, MSB first
   assign signals_next = {jump, jump_reg, branch, branch_eq,
                          alu_src_imm, i_format, alu_op, dst_ra,
                          mem_read, mem_write, mem_unsigned, mem_width,
                          mem_to_reg, reg_write, link, halt};

   // Output register: reset clears, stall holds, otherwise load decode
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         signals_reg <= '0;
      end else if (i_enable) begin
         signals_reg <= signals_next;
      end
   end

   assign o_signals = signals_reg;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed sweeps followed by randomized traffic, checked
// against a table-driven reference of the decoder plus a one-word model of
// the output register (reset / hold / load).
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [19:0] sig;

   int tests = 0;
   int fails = 0;
   logic [19:0] exp_word = '0;

   control_unit #(.NB_SGN(20), .NB_OP(6)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_enable       (enable),
      .i_inst_opcode  (opcode),
      .i_inst_function(funct),
      .o_signals      (sig)
   );

   always #5 clk = ~clk;

   // Reference: expected control word per instruction, from the field map
   function automatic logic [19:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
      logic [19:0] w;
      w = 20'h00000;
      case (op)
         6'o00: begin
            if (fn == 6'b001000)      w = 20'h40000;
            else if (fn == 6'b001001) w = 20'h40006;
            else if (fn == 6'b111111) w = 20'h00001;
            else if (fn inside {6'b000000, 6'b000010, 6'b000011, 6'b000100,
                                6'b000110, 6'b000111, 6'b100001, 6'b100011,
                                6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                6'b101010, 6'b101011})
               w = 20'h00804;
         end
         6'b000100: w = 20'h31C00;
         6'b000101: w = 20'h21C00;
         6'b000010: w = 20'h80000;
         6'b000011: w = 20'h80206;
         6'b100000: w = 20'h0C10C;
         6'b100001: w = 20'h0C11C;
         6'b100011: w = 20'h0C13C;
         6'b100100: w = 20'h0C14C;
         6'b100101: w = 20'h0C15C;
         6'b100111: w = 20'h0C17C;
         6'b101000: w = 20'h0C080;
         6'b101001: w = 20'h0C090;
         6'b101011: w = 20'h0C0B0;
         6'b001000: w = 20'h0C004;
         6'b001001: w = 20'h0C404;
         6'b001010: w = 20'h0F004;
         6'b001011: w = 20'h0F404;
         6'b001100: w = 20'h0D004;
         6'b001101: w = 20'h0D404;
         6'b001110: w = 20'h0E004;
         6'b001111: w = 20'h0E404;
         default:   w = 20'h00000;
      endcase
      return w;
   endfunction

   // Apply inputs, take one edge, update the model and compare
   task automatic step(input logic [5:0] op, input logic [5:0] fn,
                       input logic en, input logic r, input string tag);
      opcode = op;
      funct  = fn;
      enable = en;
      rst    = r;
      @(posedge clk);
      #1;
      if (r)       exp_word = 20'h00000;
      else if (en) exp_word = ref_decode(op, fn);
      tests++;
      assert (sig === exp_word) else begin
         fails++;
         $error("FAIL %s op=%b fn=%b en=%b rst=%b got %05h exp %05h",
                tag, op, fn, en, r, sig, exp_word);
      end
      $display("[TB] %-8s op=%b fn=%b en=%b rst=%b sig=%05h", tag, op, fn, en, r, sig);
   endtask

   logic [5:0] legal_ops [28] = '{6'o00, 6'o00, 6'o00, 6'b000100, 6'b000101,
                                  6'b000010, 6'b000011, 6'b100000, 6'b100001,
                                  6'b100011, 6'b100100, 6'b100101, 6'b100111,
                                  6'b101000, 6'b101001, 6'b101011, 6'b001000,
                                  6'b001001, 6'b001010, 6'b001011, 6'b001100,
                                  6'b001101, 6'b001110, 6'b001111, 6'o00,
                                  6'b111111, 6'b010000, 6'b110001};
   logic [5:0] legal_fns [18] = '{6'b001000, 6'b001001, 6'b111111, 6'b000000,
                                  6'b000010, 6'b000011, 6'b000100, 6'b000110,
                                  6'b000111, 6'b100001, 6'b100011, 6'b100100,
                                  6'b100101, 6'b100110, 6'b100111, 6'b101010,
                                  6'b101011, 6'b001100};

   initial begin
      logic [5:0] xf;
      xf = 6'bxxxxxx;
      opcode = '0; funct = '0; enable = 1'b0; rst = 1'b1;

      // reset, then stall with ADDU present, then enable
      step(6'o00, 6'b100001, 1'b0, 1'b1, "reset");
      step(6'o00, 6'b100001, 1'b0, 1'b0, "stall0");
      step(6'o00, 6'b100001, 1'b1, 1'b0, "addu");

      // branches and jumps
      step(6'b000100, xf,        1'b1, 1'b0, "beq");
      step(6'b000101, xf,        1'b1, 1'b0, "bne");
      step(6'b000010, xf,        1'b1, 1'b0, "j");
      step(6'b000011, xf,        1'b1, 1'b0, "jal");
      step(6'o00,     6'b001000, 1'b1, 1'b0, "jr");
      step(6'o00,     6'b001001, 1'b1, 1'b0, "jalr");
      step(6'o00,     6'b111111, 1'b1, 1'b0, "halt");

      // memory
      step(6'b100000, 6'h15, 1'b1, 1'b0, "lb");
      step(6'b100001, 6'h2A, 1'b1, 1'b0, "lh");
      step(6'b100011, 6'h3F, 1'b1, 1'b0, "lw");
      step(6'b100100, 6'h00, 1'b1, 1'b0, "lbu");
      step(6'b100101, 6'h08, 1'b1, 1'b0, "lhu");
      step(6'b100111, 6'h09, 1'b1, 1'b0, "lwu");
      step(6'b101000, 6'h21, 1'b1, 1'b0, "sb");
      step(6'b101001, 6'h24, 1'b1, 1'b0, "sh");
      step(6'b101011, 6'h3F, 1'b1, 1'b0, "sw");

      // immediates
      step(6'b001000, xf, 1'b1, 1'b0, "addi");
      step(6'b001001, xf, 1'b1, 1'b0, "addiu");
      step(6'b001100, xf, 1'b1, 1'b0, "andi");
      step(6'b001101, xf, 1'b1, 1'b0, "ori");
      step(6'b001110, xf, 1'b1, 1'b0, "xori");
      step(6'b001111, xf, 1'b1, 1'b0, "lui");
      step(6'b001010, xf, 1'b1, 1'b0, "slti");
      step(6'b001011, xf, 1'b1, 1'b0, "sltiu");

      // stall holds LW while SW is presented
      step(6'b100011, 6'h00, 1'b1, 1'b0, "lw_ld");
      for (int i = 0; i < 3; i++)
         step(6'b101011, 6'h00, 1'b0, 1'b0, "hold");
      step(6'b101011, 6'h00, 1'b1, 1'b0, "sw_ld");

      // illegal encodings and mid-stream reset
      step(6'b111111, 6'h00,     1'b1, 1'b0, "ill_op");
      step(6'o00,     6'b001100, 1'b1, 1'b0, "ill_fn");
      step(6'b000100, xf,        1'b1, 1'b0, "beq2");
      step(6'b000100, xf,        1'b1, 1'b1, "rst_mid");
      step(6'b000100, xf,        1'b1, 1'b0, "resume");

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [5:0] op;
         logic [5:0] fn;
         logic       en;
         logic       r;
         if ($urandom_range(0, 4) == 0) op = 6'($urandom);
         else                           op = legal_ops[$urandom_range(0, 27)];
         if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
         else                           fn = legal_fns[$urandom_range(0, 17)];
         if (op != 6'o00 && $urandom_range(0, 3) == 0) fn = xf;
         en = ($urandom_range(0, 4) != 0);
         r  = ($urandom_range(0, 19) == 0);
         step(op, fn, en, r, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
